// File: rtl/pipeline_debug_tx.sv
// Debug snapshot transmitter. On capture it latches a bus of 32-bit pipeline debug words and
// sends them as a UART 8N1 packet: header byte, the data bytes, then an XOR checksum byte.
module pipeline_debug_tx #(
  parameter int unsigned ClksPerBit = 16,
  parameter int unsigned NumWords   = 4,
  parameter logic [7:0]  Header     = 8'hA5
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     capture_i,
  input  logic [NumWords*32-1:0]   snapshot_i,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned BaudW    = $clog2(ClksPerBit);
  localparam int unsigned NumBytes = 4 * NumWords + 2;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

  state_e                 state_q;
  logic [BaudW-1:0]       baud_q;
  logic [2:0]             bit_q;
  logic [6:0]             byte_q;
  logic [7:0]             shift_q;
  logic [7:0]             csum_q;
  logic [NumWords*32-1:0] snap_q;
  logic                   tx_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   baud_last;
  logic [9:0]             byte_off;
  logic [7:0]             data_byte;

  // byte_q counts bytes already sent, which is also the index of the next data byte:
  // word byte_q/4, most significant byte first within the word.
  always_comb begin
    baud_last = (baud_q == BaudW'(ClksPerBit - 1));
    byte_off  = {byte_q[6:2], ~byte_q[1:0], 3'b000};
    data_byte = 8'(snap_q >> byte_off);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      csum_q  <= '0;
      snap_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (capture_i) begin
            snap_q  <= snapshot_i;
            shift_q <= Header;
            byte_q  <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            csum_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_q <= '0;
            byte_q <= byte_q + 7'd1;
            if (byte_q == 7'(NumBytes - 1)) begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              tx_q    <= 1'b0;
              state_q <= StStart;
              if (byte_q == 7'(NumBytes - 2)) begin
                shift_q <= csum_q;
              end else begin
                shift_q <= data_byte;
                csum_q  <= csum_q ^ data_byte;
              end
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StDone: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_pipeline_debug_tx.sv
// Bench for pipeline_debug_tx: two instances (1 and 2 words), a UART receiver that checks
// decoded bytes against a queue of expected bytes, and a bit-edge spacing check.
module tb_pipeline_debug_tx;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        rst_a, cap_a, tx_a, busy_a, done_a;
  logic [31:0] snap_a;
  logic        rst_b, cap_b, tx_b, busy_b, done_b;
  logic [63:0] snap_b;

  always #5 clk = ~clk;

  pipeline_debug_tx #(.ClksPerBit(CPB), .NumWords(1), .Header(8'hA5)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .capture_i(cap_a), .snapshot_i(snap_a),
    .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a)
  );

  pipeline_debug_tx #(.ClksPerBit(CPB), .NumWords(2), .Header(8'hA5)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .capture_i(cap_b), .snapshot_i(snap_b),
    .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b)
  );

  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference packet: header, word 0 first, MSB byte first, XOR of data bytes last.
  task automatic push_packet(input logic [63:0] snap, input int nw);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int w = 0; w < nw; w++) begin
      for (int k = 3; k >= 0; k--) begin
        b = snap[32*w + 8*k +: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic run_until_done(input bit ch, output int bcyc, output int ndone);
    bcyc  = 0;
    ndone = 0;
    for (int i = 0; i < 5000 && ndone == 0; i++) begin
      if ((ch ? done_b : done_a) === 1'b1) begin
        ndone = 1;
      end else begin
        if ((ch ? busy_b : busy_a) === 1'b1) bcyc++;
        tick();
      end
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    int bad;
    bad = 0;
    repeat (n) begin
      tick();
      if ({tx_a, busy_a, done_a} !== 3'b100 || {tx_b, busy_b, done_b} !== 3'b100) bad++;
    end
    chk(tag, bad, 0);
  endtask

  // Receiver on the AND of both lines (only one instance transmits at a time).
  initial begin
    logic txm;
    logic tx_prev;
    bit   rx_act;
    bit   have_edge;
    int   rx_cnt;
    int   k;
    int   cyc;
    int   last_edge;
    logic [7:0] rx_sh;
    tx_prev = 1'b1;
    rx_act = 0;
    have_edge = 0;
    rx_cnt = 0;
    cyc = 0;
    last_edge = 0;
    rx_sh = '0;
    forever begin
      @(negedge clk);
      cyc++;
      txm = tx_a & tx_b;
      if (rst_a === 1'b1 || rst_b === 1'b1) begin
        rx_act = 0;
      end else if (!rx_act) begin
        if (txm === 1'b0) begin
          rx_act = 1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % CPB == CPB / 2) begin
          k = rx_cnt / CPB;
          if (k == 0) begin
            chk("rx start bit", txm, 1'b0);
          end else if (k <= 8) begin
            rx_sh[k-1] = txm;
          end else begin
            chk("rx stop bit", txm, 1'b1);
            if (exp_q.size() == 0) chk("rx byte expected", exp_q.size(), 1);
            else chk("rx byte", rx_sh, exp_q.pop_front());
            rx_act = 0;
          end
        end
      end
      if (busy_a === 1'b1 || busy_b === 1'b1) begin
        if (txm !== tx_prev) begin
          if (have_edge) chk("tx edge spacing mod CPB", (cyc - last_edge) % CPB, 0);
          last_edge = cyc;
          have_edge = 1;
        end
      end else begin
        have_edge = 0;
      end
      tx_prev = txm;
    end
  end

  initial begin
    int bc;
    int nd;
    rst_a = 1'b1; cap_a = 1'b0; snap_a = '0;
    rst_b = 1'b1; cap_b = 1'b0; snap_b = '0;
    repeat (3) tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    chk("reset tx_a", tx_a, 1'b1);
    chk("reset busy_a", busy_a, 1'b0);
    chk("reset done_a", done_a, 1'b0);
    chk("reset tx_b", tx_b, 1'b1);
    chk("reset busy_b", busy_b, 1'b0);
    chk("reset done_b", done_b, 1'b0);
    idle_check(500, "idle 500 cycles after reset");

    // Single word packet: A5 12 34 56 78 08.
    snap_a = 32'h12345678;
    cap_a = 1'b1;
    push_packet({32'h0, snap_a}, 1);
    tick();
    cap_a = 1'b0;
    chk("t1 busy after capture", busy_a, 1'b1);
    chk("t1 tx start bit", tx_a, 1'b0);
    run_until_done(1'b0, bc, nd);
    chk("t1 done seen", nd, 1);
    chk("t1 busy cycles", bc, 240);
    chk("t1 busy low in done", busy_a, 1'b0);
    chk("t1 tx idle in done", tx_a, 1'b1);
    chk("t1 all bytes received", exp_q.size(), 0);
    tick();
    chk("t1 done single cycle", done_a, 1'b0);

    // Snapshot change and second capture mid-packet are ignored.
    snap_a = 32'hDEADBEEF;
    cap_a = 1'b1;
    push_packet({32'h0, snap_a}, 1);
    tick();
    cap_a = 1'b0;
    repeat (50) tick();
    snap_a = 32'h00000000;
    cap_a = 1'b1;
    tick();
    cap_a = 1'b0;
    run_until_done(1'b0, bc, nd);
    chk("t3 done seen", nd, 1);
    chk("t3 busy cycles after recapture", bc, 189);
    idle_check(30, "t3 no second packet");
    chk("t3 all bytes received", exp_q.size(), 0);

    // Reset during data bits of byte 2 aborts the packet.
    snap_a = 32'hCAFEF00D;
    cap_a = 1'b1;
    push_packet({32'h0, snap_a}, 1);
    tick();
    cap_a = 1'b0;
    repeat (93) tick();
    rst_a = 1'b1;
    chk("t4 bytes pending at reset", exp_q.size(), 4);
    exp_q.delete();
    tick();
    rst_a = 1'b0;
    chk("t4 tx after reset", tx_a, 1'b1);
    chk("t4 busy after reset", busy_a, 1'b0);
    chk("t4 done after reset", done_a, 1'b0);
    idle_check(20, "t4 idle after abort");
    snap_a = 32'h0BADF00D;
    cap_a = 1'b1;
    push_packet({32'h0, snap_a}, 1);
    tick();
    cap_a = 1'b0;
    run_until_done(1'b0, bc, nd);
    chk("t4 done after new capture", nd, 1);
    chk("t4 busy cycles", bc, 240);
    chk("t4 all bytes received", exp_q.size(), 0);

    // Two words, back-to-back packets: 00 00 00 01 FF FF 00 00, checksum 01.
    snap_b = {32'hFFFF0000, 32'h00000001};
    cap_b = 1'b1;
    push_packet(snap_b, 2);
    tick();
    cap_b = 1'b0;
    run_until_done(1'b1, bc, nd);
    chk("t5 first done", nd, 1);
    chk("t5 first busy cycles", bc, 400);
    tick();
    chk("t5 idle cycle busy", busy_b, 1'b0);
    cap_b = 1'b1;
    push_packet(snap_b, 2);
    tick();
    cap_b = 1'b0;
    chk("t5 back-to-back busy", busy_b, 1'b1);
    chk("t5 back-to-back start bit", tx_b, 1'b0);
    run_until_done(1'b1, bc, nd);
    chk("t5 second done", nd, 1);
    chk("t5 second busy cycles", bc, 400);
    chk("t5 all bytes received", exp_q.size(), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
